// File: rtl/frame_scheduler_pkg.sv
// frame_scheduler_pkg: shared FSM state encoding, default frame/output lengths and address width.
package frame_scheduler_pkg;
  typedef enum logic [2:0] {FILL, COPY, START, RUN, DONE} state_t;
  localparam int FRAME_LEN_DEF = 1024;
  localparam int OUT_LEN_N_DEF = 1024;
  localparam int OUT_LEN_R_DEF = 576;
  localparam int ADDR_W = 10;
endpackage

// File: rtl/frame_addr_counter.sv
// frame_addr_counter: wrapping up-counter with enable, sync clear, programmable terminal count tc and co (count==tc).
// Ports: clk, rst (sync, active-high), en, clr, tc -> cnt, co.
module frame_addr_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] tc,
  output logic [W-1:0] cnt,
  output logic         co
);
  logic [W-1:0] cnt_q, cnt_d;
  assign co = cnt_q == tc;
  assign cnt = cnt_q;
  always_comb cnt_d = clr ? '0 : !en ? cnt_q : co ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: sequences input-buffer fill, buffer copy, FIR run and output-buffer writes per analysis frame.
// Inputs: clk, reset (sync, active-high), ready (ADC strobe), rising_tone (mode), copy_end, fir_end.
// Outputs: in_copy, fir_start, fir_oe, out_buf_wea, out_addr, sample_count, mode_q, collision, overrun.
// Optional: define FRAME_SCHED_STATS_EN to add frame_cnt (processed frames) and drop_cnt (dropped frames).
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int OUT_LEN_N = OUT_LEN_N_DEF,
  parameter int OUT_LEN_R = OUT_LEN_R_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic              rising_tone,
  input  logic              copy_end,
  input  logic              fir_end,
  output logic              in_copy,
  output logic              fir_start,
  output logic              fir_oe,
  output logic              out_buf_wea,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W-1:0] sample_count,
  output logic              mode_q,
  output logic              collision,
  output logic              overrun
`ifdef FRAME_SCHED_STATS_EN
  , output logic [15:0]     frame_cnt,
  output logic [7:0]        drop_cnt
`endif
);
  state_t state_q, state_d;
  logic pending_q, pending_d, overrun_q, overrun_d, mode_d;
  logic in_copy_q, in_copy_d, fir_start_q, fir_start_d, fir_oe_q, fir_oe_d;
  logic wea_q, wea_d, collision_q, collision_d;
  logic frame_done, drop, sc_co, oa_co, oa_clr, oa_en;
  logic [ADDR_W-1:0] lim;
  frame_addr_counter #(.W(ADDR_W)) u_sample_cnt (
    .clk(clk), .rst(reset), .en(ready), .clr(1'b0),
    .tc(ADDR_W'(FRAME_LEN - 1)), .cnt(sample_count), .co(sc_co)
  );
  frame_addr_counter #(.W(ADDR_W)) u_out_addr (
    .clk(clk), .rst(reset), .en(oa_en), .clr(oa_clr),
    .tc(lim), .cnt(out_addr), .co(oa_co)
  );
  always_comb begin
    frame_done = ready && sc_co;
    state_d = state_q;
    case (state_q)
      FILL:    state_d = frame_done ? COPY : FILL;
      COPY:    state_d = copy_end ? START : COPY;
      START:   state_d = RUN;
      RUN:     state_d = (wea_q && oa_co) ? DONE : RUN;
      DONE:    state_d = (pending_q || frame_done) ? COPY : FILL;
      default: state_d = FILL;
    endcase
    // Only one frame can wait for the copy; a second arrival while one is queued is lost.
    drop = frame_done && state_q != FILL && pending_q;
    pending_d = (state_q == DONE) ? 1'b0 : (frame_done && state_q != FILL) ? 1'b1 : pending_q;
    overrun_d = overrun_q || drop;
    mode_d = (state_d == COPY && state_q != COPY) ? rising_tone : mode_q;
    in_copy_d = state_d == COPY;
    fir_start_d = state_d == START;
    fir_oe_d = state_d == RUN;
    // A fir_end landing on the final write's cycle is not accepted, so the frame never over-writes.
    wea_d = fir_end && state_q == RUN && state_d == RUN;
    collision_d = ready && in_copy_q;
    lim = mode_q ? ADDR_W'(OUT_LEN_R - 1) : ADDR_W'(OUT_LEN_N - 1);
    oa_clr = state_d == START;
    oa_en = wea_q && !oa_co;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      mode_q <= 1'b0;
      in_copy_q <= 1'b0;
      fir_start_q <= 1'b0;
      fir_oe_q <= 1'b0;
      wea_q <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      mode_q <= mode_d;
      in_copy_q <= in_copy_d;
      fir_start_q <= fir_start_d;
      fir_oe_q <= fir_oe_d;
      wea_q <= wea_d;
      collision_q <= collision_d;
    end
  end
  assign in_copy = in_copy_q;
  assign fir_start = fir_start_q;
  assign fir_oe = fir_oe_q;
  assign out_buf_wea = wea_q;
  assign collision = collision_q;
  assign overrun = overrun_q;
`ifdef FRAME_SCHED_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  always_comb begin
    frame_cnt_d = (state_q == DONE) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    drop_cnt_d = (drop && drop_cnt_q != 8'hff) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter FRAME_LEN, default 1024, input samples per analysis frame.
REQ-002 Parameter OUT_LEN_N, default 1024, output samples per frame when rising_tone=0.
REQ-003 Parameter OUT_LEN_R, default 576, output samples per frame when rising_tone=1.
REQ-004 Port clk  in  1  single system clock; all logic on rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port ready  in  1  one-cycle pulse per new input sample (ADC strobe).
REQ-007 Port rising_tone  in  1  pitch-shift mode select; sampled only at frame start.
REQ-008 Port copy_end  in  1  one-cycle pulse from address generator: buffer copy finished.
REQ-009 Port fir_end  in  1  one-cycle pulse: FIR output sample valid.
REQ-010 Port in_copy  out  1  input-buffer copy phase active; owns buffer write port.
REQ-011 Port fir_start  out  1  one-cycle FIR reset/start pulse.
REQ-012 Port fir_oe  out  1  FIR enable.
REQ-013 Port out_buf_wea  out  1  output-buffer write strobe.
REQ-014 Port out_addr  out  10  output-buffer write address.
REQ-015 Port sample_count  out  10  input samples received in current frame.
REQ-016 Port mode_q  out  1  rising_tone latched for the frame in progress.
REQ-017 Port collision  out  1  one-cycle pulse: ready arrived while in_copy=1 (sample lost).
REQ-018 Port overrun  out  1  sticky: new frame completed before previous processing ended.

Function
REQ-019 FSM states FILL, COPY, START, RUN, DONE; outputs registered.
REQ-020 sample_count increments on every ready in all states, wraps FRAME_LEN-1 -> 0.
REQ-021 Frame-complete event = ready while sample_count==FRAME_LEN-1.
REQ-022 FILL: on frame-complete -> COPY next cycle; mode_q <= rising_tone same edge.
REQ-023 COPY: in_copy=1; on copy_end -> START; in_copy deasserts the cycle after copy_end.
REQ-024 START: fir_start=1 exactly one cycle, out_addr<=0, then -> RUN.
REQ-025 RUN: fir_oe=1; each fir_end gives out_buf_wea=1 on next cycle at current out_addr, out_addr then +1.
REQ-026 Write limit L = mode_q ? OUT_LEN_R-1 : OUT_LEN_N-1; write at out_addr==L -> DONE, out_addr holds L.
REQ-027 DONE: one cycle, fir_oe=0; -> COPY if pending frame flag set (clears flag), else FILL.
REQ-028 Frame-complete while not in FILL sets pending flag; if pending already set, overrun<=1 and frame dropped (flag stays 1).
REQ-029 Frame-complete in DONE: treated as pending; DONE -> COPY.
REQ-030 ready with in_copy=1: collision pulses next cycle; sample_count still increments.
REQ-031 fir_end outside RUN ignored; copy_end outside COPY ignored.
REQ-032 rising_tone change mid-frame has no effect until next frame start.

Reset
REQ-033 reset overrides all inputs same edge: state FILL, sample_count 0, out_addr 0, mode_q 0, pending 0, overrun 0.
REQ-034 All strobe outputs (in_copy, fir_start, fir_oe, out_buf_wea, collision) 0 in reset and first cycle after.
REQ-035 reset mid-RUN abandons frame; no further out_buf_wea until new frame processed.

Configuration
REQ-036 Macro FRAME_SCHED_STATS_EN defined: adds out port frame_cnt (16 b, frames fully processed, wraps) and drop_cnt (8 b, saturating, dropped frames); both cleared by reset.
REQ-037 Macro undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-038 Shared package holds state enum, default frame/output lengths, 10-bit address width constant.
REQ-039 One sub-module natural: frame_addr_counter (enable, sync clear, programmable terminal count, carry out) used for sample_count and out_addr.

Verification
REQ-040 1024 ready pulses, rising_tone=0, copy_end 20 cycles later, 1024 fir_end -> 1024 writes addr 0..1023, back to FILL, overrun=0.
REQ-041 Same with rising_tone=1 at frame start -> exactly 576 writes addr 0..575, mode_q=1.
REQ-042 Toggle rising_tone mid-RUN -> write count unchanged for current frame.
REQ-043 Second and third frames complete during RUN -> pending set, overrun=1, DONE -> COPY directly.
REQ-044 ready coincident with in_copy -> collision pulse one cycle, sample_count +1.
REQ-045 reset asserted after 300 writes -> all outputs 0 next cycle, fir_end pulses produce no writes.
